// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and constants for the matmul tile scheduler
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } mm_state_t;

    localparam int ROW_BYTES  = 16;
    localparam int ROW_SHIFT  = $clog2(ROW_BYTES);
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_TILE_W = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] a_addr;
        logic [DEF_ADDR_W-1:0] b_addr;
        logic [DEF_TILE_W-1:0] m_tiles;
        logic [DEF_TILE_W-1:0] n_tiles;
        logic [3:0]            row_len;
        logic [3:0]            col_len;
    } mm_cmd_t;

endpackage

// File: rtl/mm_tile_addr_gen.sv
// rtl/mm_tile_addr_gen.sv - tile index counters and per-tile A/B start addresses
module mm_tile_addr_gen
    import mm_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TILE_W = DEF_TILE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_adv,
    input  logic [ADDR_W-1:0] i_a_base,
    input  logic [ADDR_W-1:0] i_b_base,
    input  logic [TILE_W-1:0] i_m_tiles,
    input  logic [TILE_W-1:0] i_n_tiles,
    input  logic [3:0]        i_row_len,
    output logic [TILE_W-1:0] o_m_idx,
    output logic [TILE_W-1:0] o_n_idx,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_a_addr,
    output logic [ADDR_W-1:0] o_b_addr
);

    localparam int STRIDE_W = ROW_SHIFT + 5;
    localparam int PROD_W   = TILE_W + STRIDE_W;

    logic [ADDR_W-1:0]   r_a_base, r_b_base, r_a_addr, r_b_addr;
    logic [TILE_W-1:0]   r_m_max, r_n_max, r_m, r_n;
    logic [STRIDE_W-1:0] r_stride;

    logic                w_n_wrap;
    logic [TILE_W-1:0]   w_m_nxt, w_n_nxt;
    logic [PROD_W-1:0]   w_a_off, w_b_off;
    logic [4:0]          w_rows;
    logic [STRIDE_W-1:0] w_ld_stride;

    assign w_n_wrap    = (r_n == r_n_max);
    assign w_m_nxt     = w_n_wrap ? r_m + 1'b1 : r_m;
    assign w_n_nxt     = w_n_wrap ? '0 : r_n + 1'b1;
    assign w_a_off     = PROD_W'(w_m_nxt) * PROD_W'(r_stride);
    assign w_b_off     = PROD_W'(w_n_nxt) * PROD_W'(r_stride);
    assign w_rows      = {1'b0, i_row_len} + 5'd1;
    assign w_ld_stride = STRIDE_W'(w_rows) << ROW_SHIFT;

    // Offsets wrap modulo 2^ADDR_W by truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_base <= '0;
            r_b_base <= '0;
            r_m_max  <= '0;
            r_n_max  <= '0;
            r_stride <= '0;
            r_m      <= '0;
            r_n      <= '0;
            r_a_addr <= '0;
            r_b_addr <= '0;
        end else if (i_load) begin
            r_a_base <= i_a_base;
            r_b_base <= i_b_base;
            r_m_max  <= i_m_tiles;
            r_n_max  <= i_n_tiles;
            r_stride <= w_ld_stride;
            r_m      <= '0;
            r_n      <= '0;
            r_a_addr <= i_a_base;
            r_b_addr <= i_b_base;
        end else if (i_adv) begin
            r_m      <= w_m_nxt;
            r_n      <= w_n_nxt;
            r_a_addr <= r_a_base + ADDR_W'(w_a_off);
            r_b_addr <= r_b_base + ADDR_W'(w_b_off);
        end
    end

    assign o_m_idx  = r_m;
    assign o_n_idx  = r_n;
    assign o_last   = (r_m == r_m_max) && w_n_wrap;
    assign o_a_addr = r_a_addr;
    assign o_b_addr = r_b_addr;

endmodule

// File: rtl/mm_tile_sched.sv
// rtl/mm_tile_sched.sv - M x N tile scheduler for A/B operand buffers; MM_TILE_SCHED_PERF_CNT_EN adds perf counters
module mm_tile_sched
    import mm_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TILE_W = DEF_TILE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [ADDR_W-1:0] cmd_a_addr,
    input  logic [ADDR_W-1:0] cmd_b_addr,
    input  logic [TILE_W-1:0] cmd_m_tiles,
    input  logic [TILE_W-1:0] cmd_n_tiles,
    input  logic [3:0]        cmd_row_len,
    input  logic [3:0]        cmd_col_len,
    output logic              a_ctrl_vld,
    output logic              b_ctrl_vld,
    output logic [3:0]        a_ctrl_row_len,
    output logic [3:0]        b_ctrl_row_len,
    output logic [3:0]        a_ctrl_col_len,
    output logic [3:0]        b_ctrl_col_len,
    output logic [ADDR_W-1:0] a_ctrl_start_addr,
    output logic [ADDR_W-1:0] b_ctrl_start_addr,
    input  logic              a_mxu_end,
    input  logic              b_mxu_end,
    output logic              tile_vld,
    input  logic              tile_rdy,
    output logic [TILE_W-1:0] tile_m_idx,
    output logic [TILE_W-1:0] tile_n_idx,
    output logic              busy,
    output logic              done
`ifdef MM_TILE_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
`endif
);

    mm_state_t r_state, w_state_nxt;
    mm_cmd_t   w_cmd;
    logic      r_a_seen, r_b_seen, r_first;
    logic      w_a_seen, w_b_seen, w_load, w_adv, w_last, w_done_nxt;
    logic      r_cmd_rdy, r_ctrl_vld, r_tile_vld, r_busy, r_done;
    logic      w_cmd_rdy_nxt, w_ctrl_vld_nxt, w_tile_vld_nxt, w_busy_nxt;
    logic [3:0] r_row_len, r_col_len;

    assign w_cmd = '{a_addr: cmd_a_addr, b_addr: cmd_b_addr, m_tiles: cmd_m_tiles,
                     n_tiles: cmd_n_tiles, row_len: cmd_row_len, col_len: cmd_col_len};

    // The first LOAD cycle masks end inputs that may still be left over from the previous tile.
    assign w_a_seen = r_a_seen | (a_mxu_end & ~r_first);
    assign w_b_seen = r_b_seen | (b_mxu_end & ~r_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: if (cmd_vld) begin
                w_state_nxt = ST_LOAD;
                w_load      = 1'b1;
            end
            ST_LOAD: if (w_a_seen && w_b_seen) w_state_nxt = ST_ACK;
            ST_ACK: if (tile_rdy) begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_LOAD;
                    w_adv       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_rdy_nxt  = (w_state_nxt == ST_IDLE);
        w_ctrl_vld_nxt = (w_state_nxt == ST_LOAD);
        w_tile_vld_nxt = (w_state_nxt == ST_ACK);
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_seen   <= 1'b0;
            r_b_seen   <= 1'b0;
            r_first    <= 1'b0;
            r_cmd_rdy  <= 1'b1;
            r_ctrl_vld <= 1'b0;
            r_tile_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_row_len  <= '0;
            r_col_len  <= '0;
        end else begin
            r_a_seen   <= (r_state == ST_LOAD) && (w_state_nxt == ST_LOAD) && w_a_seen;
            r_b_seen   <= (r_state == ST_LOAD) && (w_state_nxt == ST_LOAD) && w_b_seen;
            r_first    <= (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
            r_cmd_rdy  <= w_cmd_rdy_nxt;
            r_ctrl_vld <= w_ctrl_vld_nxt;
            r_tile_vld <= w_tile_vld_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (w_load) begin
                r_row_len <= w_cmd.row_len;
                r_col_len <= w_cmd.col_len;
            end
        end
    end

    mm_tile_addr_gen #(.ADDR_W(ADDR_W), .TILE_W(TILE_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_adv     (w_adv),
        .i_a_base  (w_cmd.a_addr),
        .i_b_base  (w_cmd.b_addr),
        .i_m_tiles (w_cmd.m_tiles),
        .i_n_tiles (w_cmd.n_tiles),
        .i_row_len (w_cmd.row_len),
        .o_m_idx   (tile_m_idx),
        .o_n_idx   (tile_n_idx),
        .o_last    (w_last),
        .o_a_addr  (a_ctrl_start_addr),
        .o_b_addr  (b_ctrl_start_addr)
    );

    assign cmd_rdy        = r_cmd_rdy;
    assign a_ctrl_vld     = r_ctrl_vld;
    assign b_ctrl_vld     = r_ctrl_vld;
    assign a_ctrl_row_len = r_row_len;
    assign b_ctrl_row_len = r_row_len;
    assign a_ctrl_col_len = r_col_len;
    assign b_ctrl_col_len = r_col_len;
    assign tile_vld       = r_tile_vld;
    assign busy           = r_busy;
    assign done           = r_done;

`ifdef MM_TILE_SCHED_PERF_CNT_EN
    logic [31:0] r_perf_busy, r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (w_load) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_busy && (r_perf_busy != '1))
                r_perf_busy <= r_perf_busy + 32'd1;
            if (r_tile_vld && !tile_rdy && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_busy_cyc  = r_perf_busy;
    assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_mm_tile_sched.sv
// tb/tb_mm_tile_sched.sv - scoreboard bench for mm_tile_sched (perf ports when MM_TILE_SCHED_PERF_CNT_EN)
module tb_mm_tile_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_vld, cmd_rdy;
    logic [11:0] cmd_a_addr, cmd_b_addr;
    logic [3:0]  cmd_m_tiles, cmd_n_tiles, cmd_row_len, cmd_col_len;
    logic        a_ctrl_vld, b_ctrl_vld;
    logic [3:0]  a_ctrl_row_len, b_ctrl_row_len, a_ctrl_col_len, b_ctrl_col_len;
    logic [11:0] a_ctrl_start_addr, b_ctrl_start_addr;
    logic        a_mxu_end, b_mxu_end;
    logic        tile_vld, tile_rdy;
    logic [3:0]  tile_m_idx, tile_n_idx;
    logic        busy, done;
`ifdef MM_TILE_SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

    always #5 clk = ~clk;

    mm_tile_sched dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr),
        .cmd_m_tiles(cmd_m_tiles), .cmd_n_tiles(cmd_n_tiles),
        .cmd_row_len(cmd_row_len), .cmd_col_len(cmd_col_len),
        .a_ctrl_vld(a_ctrl_vld), .b_ctrl_vld(b_ctrl_vld),
        .a_ctrl_row_len(a_ctrl_row_len), .b_ctrl_row_len(b_ctrl_row_len),
        .a_ctrl_col_len(a_ctrl_col_len), .b_ctrl_col_len(b_ctrl_col_len),
        .a_ctrl_start_addr(a_ctrl_start_addr), .b_ctrl_start_addr(b_ctrl_start_addr),
        .a_mxu_end(a_mxu_end), .b_mxu_end(b_mxu_end),
        .tile_vld(tile_vld), .tile_rdy(tile_rdy),
        .tile_m_idx(tile_m_idx), .tile_n_idx(tile_n_idx),
        .busy(busy), .done(done)
`ifdef MM_TILE_SCHED_PERF_CNT_EN
        , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    typedef struct {
        int m, n, a, b, load_len, ack_len;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, done_seen = 0;
    int   a_dly = 8, b_dly = 8, stall_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int m, input int n, input int a, input int b,
                        input int ll, input int al, input bit last);
        exp_t e;
        e.m = m; e.n = n; e.a = a; e.b = b; e.load_len = ll; e.ack_len = al; e.last = last;
        sb.push_back(e);
    endtask

    // Buffer models: end rises in the a_dly/b_dly-th cycle of ctrl_vld and stays one cycle.
    initial begin
        int cnt = 0;
        a_mxu_end = 1'b0;
        forever begin
            @(negedge clk);
            if (a_ctrl_vld) begin cnt++; a_mxu_end = (cnt == a_dly); end
            else begin cnt = 0; a_mxu_end = 1'b0; end
        end
    end

    initial begin
        int cnt = 0;
        b_mxu_end = 1'b0;
        forever begin
            @(negedge clk);
            if (b_ctrl_vld) begin cnt++; b_mxu_end = (cnt == b_dly); end
            else begin cnt = 0; b_mxu_end = 1'b0; end
        end
    end

    initial begin
        int cnt = 0;
        tile_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (tile_vld) begin
                if (cnt < stall_req) begin tile_rdy = 1'b0; cnt++; end
                else tile_rdy = 1'b1;
            end else begin
                tile_rdy = 1'b1;
                cnt = 0;
            end
        end
    end

    // Monitor: pops one entry per accepted tile and checks timing, indices and addresses.
    initial begin
        int  load_cnt = 0, ack_cnt = 0;
        bit  exp_done = 0;
        logic [3:0] m0 = '0, n0 = '0;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                load_cnt = 0; ack_cnt = 0; exp_done = 0;
            end else begin
                if (exp_done || done) chk("done_pulse", done, exp_done);
                if (done) done_seen++;
                exp_done = 0;
                if (a_ctrl_vld) load_cnt++;
                if (tile_vld) begin
                    ack_cnt++;
                    chk("ctrl_vld_low_in_ack", {a_ctrl_vld, b_ctrl_vld}, 2'b00);
                    if (ack_cnt == 1) begin
                        m0 = tile_m_idx; n0 = tile_n_idx;
                    end else begin
                        chk("idx_stable", {tile_m_idx, tile_n_idx}, {m0, n0});
                    end
                    if (tile_rdy) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_tile", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("tile_m_idx", tile_m_idx, e.m);
                            chk("tile_n_idx", tile_n_idx, e.n);
                            chk("a_start_addr", a_ctrl_start_addr, e.a);
                            chk("b_start_addr", b_ctrl_start_addr, e.b);
                            chk("load_cycles", load_cnt, e.load_len);
                            chk("ack_cycles", ack_cnt, e.ack_len);
                            exp_done = e.last;
                        end
                        load_cnt = 0; ack_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input int a, input int b, input int m, input int n,
                         input int row, input int col);
        int guard = 0;
        @(negedge clk);
        while (!cmd_rdy && guard < 200) begin @(negedge clk); guard++; end
        if (!cmd_rdy) chk("cmd_rdy_timeout", 0, 1);
        cmd_vld = 1'b1; cmd_a_addr = 12'(a); cmd_b_addr = 12'(b);
        cmd_m_tiles = 4'(m); cmd_n_tiles = 4'(n);
        cmd_row_len = 4'(row); cmd_col_len = 4'(col);
        @(negedge clk);
        cmd_vld = 1'b0;
        chk("accept_ctrl_vld", {a_ctrl_vld, b_ctrl_vld, busy, cmd_rdy}, 4'b1110);
        chk("accept_a_addr", a_ctrl_start_addr, 64'(a));
        chk("accept_b_addr", b_ctrl_start_addr, 64'(b));
        chk("accept_lens", {a_ctrl_row_len, b_ctrl_row_len, a_ctrl_col_len, b_ctrl_col_len},
            {4'(row), 4'(row), 4'(col), 4'(col)});
    endtask

    task automatic wait_done(input int budget);
        int start = done_seen;
        int t = 0;
        while (done_seen == start && t < budget) begin @(negedge clk); #2; t++; end
        if (done_seen == start) chk("done_timeout", 0, 1);
        else chk("idle_after_done", {busy, cmd_rdy, tile_vld, a_ctrl_vld}, 4'b0100);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n = 1'b0; cmd_vld = 1'b0;
        cmd_a_addr = '0; cmd_b_addr = '0; cmd_m_tiles = '0; cmd_n_tiles = '0;
        cmd_row_len = '0; cmd_col_len = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_rdy", cmd_rdy, 1);
        chk("reset_outputs_zero", {a_ctrl_vld, b_ctrl_vld, a_ctrl_row_len, b_ctrl_row_len,
            a_ctrl_col_len, b_ctrl_col_len, a_ctrl_start_addr, b_ctrl_start_addr,
            tile_vld, tile_m_idx, tile_n_idx, busy, done}, 64'd0);
        rst_n = 1'b1;

        // Single tile, ends 8 cycles in.
        a_dly = 8; b_dly = 8; stall_req = 0;
        push(0, 0, 'h100, 'h200, 8, 1, 1);
        issue('h100, 'h200, 0, 0, 3, 3);
        wait_done(100);

        // 2x3 grid, row_len=1 -> stride 0x20; cmd_vld while busy must be ignored.
        a_dly = 4; b_dly = 4;
        push(0, 0, 'h100, 'h200, 4, 1, 0);
        push(0, 1, 'h100, 'h220, 4, 1, 0);
        push(0, 2, 'h100, 'h240, 4, 1, 0);
        push(1, 0, 'h120, 'h200, 4, 1, 0);
        push(1, 1, 'h120, 'h220, 4, 1, 0);
        push(1, 2, 'h120, 'h240, 4, 1, 1);
        issue('h100, 'h200, 1, 2, 1, 2);
        cmd_vld = 1'b1; cmd_a_addr = 'h7F0; cmd_b_addr = 'h7F0;
        cmd_m_tiles = 4'd5; cmd_n_tiles = 4'd5;
        repeat (3) begin
            @(negedge clk);
            chk("cmd_rdy_low_busy", cmd_rdy, 0);
        end
        cmd_vld = 1'b0;
        wait_done(200);

        // Skewed ends: b pulses in cycle 3 and drops, a arrives in cycle 8.
        a_dly = 8; b_dly = 3;
        push(0, 0, 'h040, 'h080, 8, 1, 1);
        issue('h040, 'h080, 0, 0, 2, 5);
        wait_done(100);

        // Drain backpressure for 10 cycles.
        a_dly = 8; b_dly = 8; stall_req = 10;
        push(0, 0, 'h100, 'h200, 8, 11, 1);
        issue('h100, 'h200, 0, 0, 3, 3);
        wait_done(100);
`ifdef MM_TILE_SCHED_PERF_CNT_EN
        chk("perf_stall_cyc", perf_stall_cyc, 10);
        chk("perf_busy_cyc", perf_busy_cyc, 19);
`endif
        stall_req = 0;

        // Address wrap: 0xFF0 + 1*0x100 wraps to 0x0F0.
        a_dly = 2; b_dly = 2;
        push(0, 0, 'hFF0, 'h000, 2, 1, 0);
        push(1, 0, 'h0F0, 'h000, 2, 1, 1);
        issue('hFF0, 'h000, 1, 0, 15, 15);
        wait_done(100);

        // Reset while the second tile is loading.
        a_dly = 6; b_dly = 6;
        push(0, 0, 'h300, 'h400, 6, 1, 0);
        issue('h300, 'h400, 0, 2, 0, 1);
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
        chk("first_tile_before_reset", sb.size(), 0);
        repeat (3) @(negedge clk);
        chk("tile2_loading", {a_ctrl_vld, tile_n_idx, b_ctrl_start_addr}, {1'b1, 4'd1, 12'h410});
        rst_n = 1'b0;
        @(negedge clk);
        chk("midload_reset_cmd_rdy", cmd_rdy, 1);
        chk("midload_reset_zero", {a_ctrl_vld, b_ctrl_vld, a_ctrl_row_len, b_ctrl_row_len,
            a_ctrl_col_len, b_ctrl_col_len, a_ctrl_start_addr, b_ctrl_start_addr,
            tile_vld, tile_m_idx, tile_n_idx, busy, done}, 64'd0);
        rst_n = 1'b1;
        sb.delete();
        a_dly = 5; b_dly = 5;
        push(0, 0, 'h500, 'h600, 5, 1, 1);
        issue('h500, 'h600, 0, 0, 4, 4);
        wait_done(100);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_tile_sched.md
# mm_tile_sched

Tile scheduler that sequences a pair of matrix-operand buffers (A = activation rows, B = weight rows) feeding the MXU. It accepts one matmul command, walks an M×N grid of tiles, drives each buffer's level-style control bundle (vld, row_len, col_len, start_addr), waits for both buffers to report end-of-stream, and hands each finished tile to a downstream drain through a valid/ready handshake. It sits between the LSU command path and the two operand buffers.

## Interface
Parameters:
- ADDR_W, 12, byte address width of buffer start_addr.
- TILE_W, 4, width of tile-count fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command ready; high only in IDLE.
- cmd_a_addr  in  ADDR_W  A base byte address.
- cmd_b_addr  in  ADDR_W  B base byte address.
- cmd_m_tiles  in  TILE_W  A tile count minus 1.
- cmd_n_tiles  in  TILE_W  B tile count minus 1.
- cmd_row_len  in  4  per-tile row_len, last row index.
- cmd_col_len  in  4  per-tile col_len, last column index.
- a_ctrl_vld, b_ctrl_vld  out  1  buffer control valid, level.
- a_ctrl_row_len, b_ctrl_row_len  out  4  latched cmd_row_len.
- a_ctrl_col_len, b_ctrl_col_len  out  4  latched cmd_col_len.
- a_ctrl_start_addr, b_ctrl_start_addr  out  ADDR_W  tile start address.
- a_mxu_end, b_mxu_end  in  1  buffer end indication, level.
- tile_vld  out  1  tile complete, held until accepted.
- tile_rdy  in  1  drain accepts tile.
- tile_m_idx, tile_n_idx  out  TILE_W  indices of the tile reported by tile_vld.
- busy  out  1  high from cmd accept to final tile accept.
- done  out  1  one-cycle pulse after the last tile is accepted.

## Operation
- States: IDLE, LOAD, ACK.
- IDLE: cmd_rdy=1. On cmd_vld: latch all cmd fields, m_idx=n_idx=0, go to LOAD.
- LOAD: a/b_ctrl_vld=1. Sticky flags a_seen/b_seen set on a/b_mxu_end. End inputs are ignored in the first LOAD cycle. When both flags are set (including when both are set in the same cycle), clear the flags and go to ACK.
- ACK: ctrl_vld=0, tile_vld=1. On tile_rdy:
  - If m_idx==m_tiles and n_idx==n_tiles: pulse done and go to IDLE.
  - Otherwise advance the indices, n inner then m outer: n wraps to 0 and m increments. Then go to LOAD.
- Address arithmetic:
  - stride = (row_len+1)<<4.
  - a_addr = a_base + m_idx*stride; b_addr = b_base + n_idx*stride.
  - Results are truncated to ADDR_W, so wrap-around is modulo 2^ADDR_W. Low nibble comes from the base.
- ACK guarantees at least one low cycle of ctrl_vld between tiles, giving the buffer a fresh rising edge for its start pulse.
- cmd_vld outside IDLE is ignored; the command is not consumed.
- Reset at any point returns to IDLE, clears the flags, and drops every output.

## Timing
- All outputs are registered.
- Reset values: cmd_rdy=1; every other output 0, including addresses and indices.
- Cmd accepted at edge T → ctrl_vld=1 from T+1, with start_addr valid in the same cycle.
- Both ends seen at edge E → ctrl_vld=0 and tile_vld=1 from E+1.
- tile_rdy at edge R → ctrl_vld=1 again from R+1, or done=1 in R+1 for the last tile.
- Minimum per-tile overhead: 2 cycles beyond buffer latency.
- Single tile, zero-stall drain: done appears 3 cycles after the later end input.

## Configuration
- MM_TILE_SCHED_PERF_CNT_EN defined:
  - Adds outputs perf_busy_cyc[31:0], counting cycles with busy=1.
  - Adds perf_stall_cyc[31:0], counting cycles with tile_vld=1 and tile_rdy=0.
  - Both counters clear on cmd accept, saturate at all-ones, and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package mm_pkg holds:
  - the state enum;
  - ROW_BYTES=16;
  - default ADDR_W/TILE_W;
  - the command struct (bases, tile counts, row/col len).
- One sub-module, mm_tile_addr_gen: owns m/n index counters, wrap/last detection, stride multiply and the two start addresses. FSM drives its load/advance strobes.

## Test plan
- Single tile: a=0x100, b=0x200, m=n=0, row=3, col=3; ends 8 cycles after ctrl_vld → one tile_vld (0,0), done one cycle after tile_rdy, a/b_start_addr = 0x100/0x200.
- 2×3 grid, row=1: tile order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); b addresses 0x200,0x220,0x240 repeat; a steps 0x100→0x120; ctrl_vld low for exactly 1 cycle between tiles when tile_rdy is tied high.
- Skewed ends: b_mxu_end 5 cycles before a_mxu_end; b_mxu_end drops before a rises → tile_vld only after a_mxu_end, one cycle later.
- Drain backpressure: tile_rdy low 10 cycles → tile_vld held, indices stable, ctrl_vld stays 0, perf_stall_cyc=10 with MM_TILE_SCHED_PERF_CNT_EN.
- Address wrap: a=0xFF0, row=15, m=1 → second A tile start_addr 0x0F0.
- Reset mid-LOAD on tile 2 → all outputs 0 and cmd_rdy=1 next cycle; a new command starts cleanly at (0,0).
